sram_like_responder: RTL and testbench

SRAM_LIKE_RESPONDER -- requirements
Module: sram_like_responder

---
 rtl/sram_like_responder.sv | 109 ++++++++++
 tb/tb_sram_like_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_responder.sv
// SRAM-like slave: in-order request FIFO with a per-entry latency countdown
// in front of a byte-writable word memory.
module sram_like_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2,
  parameter int DEPTH     = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int            AW       = $clog2(MEM_WORDS);
  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [2:0]    OCC_MAX  = 3'(DEPTH);
  localparam logic [2:0]    LAT_LOAD = 3'(LATENCY);

  logic [31:0]   r_mem   [MEM_WORDS];
  logic          r_wr    [DEPTH];
  logic [3:0]    r_strb  [DEPTH];
  logic [AW-1:0] r_idx   [DEPTH];
  logic [31:0]   r_wdata [DEPTH];
  logic [2:0]    r_cnt   [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [2:0]    r_occ;

  logic          w_retire;
  logic          w_accept;
  logic [PW-1:0] w_rd_nxt;
  logic [PW-1:0] w_wr_nxt;
  logic          w_unused;

  // Head retires when its countdown is already 0 or hits 0 at this edge.
  assign w_retire = (r_occ != 3'd0) && (r_cnt[r_rd_ptr] <= 3'd1);
  assign addr_ok  = (r_occ < OCC_MAX) || w_retire;
  assign w_accept = req && addr_ok;
  assign w_rd_nxt = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
  assign w_wr_nxt = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
  assign w_unused = ^{size, addr[31:AW+2], addr[1:0]};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
      data_ok  <= 1'b0;
      rdata    <= '0;
    end else begin
      data_ok <= w_retire;
      if (w_retire) begin
        r_rd_ptr <= w_rd_nxt;
        if (!r_wr[r_rd_ptr]) begin
          rdata <= r_mem[r_idx[r_rd_ptr]];
        end
      end
      if (w_accept) begin
        r_wr_ptr <= w_wr_nxt;
      end
      case ({w_accept, w_retire})
        2'b10:   r_occ <= r_occ + 3'd1;
        2'b01:   r_occ <= r_occ - 3'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (r_cnt[i] != 3'd0) begin
          r_cnt[i] <= r_cnt[i] - 3'd1;
        end
      end
      // A full FIFO may accept into the retiring slot; the head is read before overwrite.
      if (w_accept) begin
        r_wr[r_wr_ptr]    <= wr;
        r_strb[r_wr_ptr]  <= wstrb;
        r_idx[r_wr_ptr]   <= addr[AW+1:2];
        r_wdata[r_wr_ptr] <= wdata;
        r_cnt[r_wr_ptr]   <= LAT_LOAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && w_retire && r_wr[r_rd_ptr]) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (r_strb[r_rd_ptr][b]) begin
          r_mem[r_idx[r_rd_ptr]][b*8 +: 8] <= r_wdata[r_rd_ptr][b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder: four parameterisations share one stimulus
// stream, each with its own timing model and response scoreboard.
module tb_sram_like_responder;

  typedef struct {
    bit          wr;
    bit [9:0]    idx;
    bit [3:0]    strb;
    bit [31:0]   data;
    int          due;
  } txn_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%08h, expected 0x%08h", tag, cyc, got, exp);
    end
  endtask

  for (genvar k = 0; k < 4; k++) begin : g_dut
    localparam int LAT = (k == 0) ? 2 : (k == 1) ? 1 : (k == 2) ? 4 : 3;
    localparam int DEP = (k == 0) ? 2 : (k == 1) ? 2 : (k == 2) ? 2 : 3;

    logic        aok;
    logic        dok;
    logic [31:0] rd;

    sram_like_responder #(
      .MEM_WORDS(1024),
      .LATENCY  (LAT),
      .DEPTH    (DEP)
    ) u_dut (
      .clk    (clk),
      .resetn (resetn),
      .req    (req),
      .wr     (wr),
      .size   (size),
      .wstrb  (wstrb),
      .addr   (addr),
      .wdata  (wdata),
      .addr_ok(aok),
      .data_ok(dok),
      .rdata  (rd)
    );

    txn_t      q[$];
    bit [31:0] mm [1024];
    bit [31:0] lastr    = '0;
    int        last_due = 0;
    txn_t      t;
    bit        e_dok;
    bit        e_aok;
    int        occ;
    int        due;

    always @(negedge clk) begin
      if (cyc >= 1) begin
        e_dok = (q.size() > 0) && (q[0].due == cyc);
        check($sformatf("dut%0d data_ok", k), 32'(dok), 32'(e_dok));
        if (e_dok) begin
          t = q.pop_front();
          if (t.wr) begin
            for (int b = 0; b < 4; b++) begin
              if (t.strb[b]) mm[t.idx][b*8 +: 8] = t.data[b*8 +: 8];
            end
          end else begin
            lastr = mm[t.idx];
          end
        end
        check($sformatf("dut%0d rdata", k), rd, lastr);

        occ   = q.size();
        e_aok = (occ < DEP) || (occ > 0 && q[0].due == cyc + 1);
        check($sformatf("dut%0d addr_ok", k), 32'(aok), 32'(e_aok));

        if (!resetn) begin
          q.delete();
          lastr    = '0;
          last_due = 0;
        end else if (req && e_aok) begin
          due = cyc + LAT + 1;
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          t.wr   = wr;
          t.idx  = addr[11:2];
          t.strb = wstrb;
          t.data = wdata;
          t.due  = due;
          q.push_back(t);
        end
      end
    end
  end

  task automatic send(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    req   = 1'b1;
    wr    = w;
    wstrb = s;
    addr  = a;
    wdata = d;
    size  = 2'd2;
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    resetn = 1'b0;
    req    = 1'b0;
    wr     = 1'b0;
    size   = 2'd0;
    wstrb  = 4'h0;
    addr   = '0;
    wdata  = '0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    idle(2);

    for (int i = 0; i < 32; i++) begin
      send(1'b1, 4'hF, 32'(i * 4), 32'hA500_0000 | 32'(i));
      idle(6);
    end

    send(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    idle(4);
    send(1'b0, 4'h0, 32'h10, 32'h0);
    idle(6);

    send(1'b1, 4'hF, 32'h20, 32'h1122_3344);
    send(1'b1, 4'b0010, 32'h20, 32'h0000_AA00);
    send(1'b0, 4'hF, 32'h20, 32'h0);
    idle(8);

    send(1'b1, 4'h0, 32'h20, 32'hFFFF_FFFF);
    idle(2);
    send(1'b0, 4'hF, 32'h20, 32'h0);
    idle(8);

    send(1'b1, 4'hF, 32'h1000, 32'hCAFE_F00D);
    idle(6);
    send(1'b0, 4'hF, 32'h0, 32'h0);
    idle(8);

    send(1'b0, 4'h0, 32'h10, 32'h0);
    send(1'b0, 4'h0, 32'h20, 32'h0);
    send(1'b0, 4'h0, 32'h00, 32'h0);
    send(1'b0, 4'h0, 32'h1010, 32'h0);
    idle(12);

    for (int i = 0; i < 40; i++) begin
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom);
    end
    idle(20);

    send(1'b1, 4'hF, 32'h40, 32'h0000_0077);
    idle(8);
    send(1'b1, 4'hF, 32'h40, 32'h0000_0055);
    resetn = 1'b0;
    idle(2);
    resetn = 1'b1;
    idle(2);
    send(1'b0, 4'hF, 32'h40, 32'h0);
    idle(30);

    check("dut0 drain", 32'(g_dut[0].q.size()), 32'd0);
    check("dut1 drain", 32'(g_dut[1].q.size()), 32'd0);
    check("dut2 drain", 32'(g_dut[2].q.size()), 32'd0);
    check("dut3 drain", 32'(g_dut[3].q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
